// File: rtl/tmult_arbiter_if.sv
// tmult_arbiter_if
//   Bundles the request, multiplier and response channels of tmult_arbiter.
//   Modport master is the arbiter's view. Modport slave is the view of the
//   surrounding lanes, the multiplier and the response sink.
//
//   Signals:
//     s_req_a_tdata / s_req_b_tdata  NREQ*W  operand pairs, requester i at [i*W +: W]
//     s_req_tvalid / s_req_tready    NREQ    per-requester handshake
//     mul_a_*, mul_b_*               W/1/1   operand channels to the multiplier
//     mul_z_*                        W/1/1   product channel from the multiplier
//     m_rsp_tdata / m_rsp_tdest      W/IDW   product and requester index
//     m_rsp_tvalid / m_rsp_tready    1/1     response handshake
interface tmult_arbiter_if #(
    parameter int NREQ = 4,
    parameter int EXP  = 5,
    parameter int FRA  = 10
);
    localparam int W   = EXP + FRA + 1;
    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [NREQ*W-1:0] s_req_a_tdata;
    logic [NREQ*W-1:0] s_req_b_tdata;
    logic [NREQ-1:0]   s_req_tvalid;
    logic [NREQ-1:0]   s_req_tready;

    logic [W-1:0]      mul_a_tdata;
    logic              mul_a_tvalid;
    logic              mul_a_tready;
    logic [W-1:0]      mul_b_tdata;
    logic              mul_b_tvalid;
    logic              mul_b_tready;
    logic [W-1:0]      mul_z_tdata;
    logic              mul_z_tvalid;
    logic              mul_z_tready;

    logic [W-1:0]      m_rsp_tdata;
    logic [IDW-1:0]    m_rsp_tdest;
    logic              m_rsp_tvalid;
    logic              m_rsp_tready;

    modport master (
        input  s_req_a_tdata, s_req_b_tdata, s_req_tvalid,
        output s_req_tready,
        output mul_a_tdata, mul_a_tvalid,
        input  mul_a_tready,
        output mul_b_tdata, mul_b_tvalid,
        input  mul_b_tready,
        input  mul_z_tdata, mul_z_tvalid,
        output mul_z_tready,
        output m_rsp_tdata, m_rsp_tdest, m_rsp_tvalid,
        input  m_rsp_tready
    );

    modport slave (
        output s_req_a_tdata, s_req_b_tdata, s_req_tvalid,
        input  s_req_tready,
        input  mul_a_tdata, mul_a_tvalid,
        output mul_a_tready,
        input  mul_b_tdata, mul_b_tvalid,
        output mul_b_tready,
        output mul_z_tdata, mul_z_tvalid,
        input  mul_z_tready,
        input  m_rsp_tdata, m_rsp_tdest, m_rsp_tvalid,
        output m_rsp_tready
    );
endinterface

// File: rtl/tmult_arbiter.sv
// tmult_arbiter
//   Round-robin arbiter sharing one multi-cycle float multiplier between NREQ
//   requesters, one operation in flight. A granted pair is sent as A then B,
//   the product is captured and returned tagged with the requester index.
//
//   Ports:
//     aclk         clock
//     aresetn      synchronous active-low reset (shared with the multiplier)
//     bus          tmult_arbiter_if.master: request, multiplier, response channels
//     busy         high whenever the FSM is not in IDLE
//     timeout_err  sticky watchdog flag (only with TMULT_ARB_TIMEOUT_EN)
//
//   Optional feature: define TMULT_ARB_TIMEOUT_EN to add a watchdog that
//   abandons an operation after TIMEOUT cycles and returns a canonical qNaN.
//
//   state  | meaning
//   IDLE   | arbitrating; s_req_tready carries the one-hot grant
//   SEND_A | presenting latched operand A to the multiplier
//   SEND_B | presenting latched operand B to the multiplier
//   WAIT_Z | ready for the product
//   RESP   | holding the product on the response stream
module tmult_arbiter #(
    parameter int NREQ = 4,
    parameter int EXP  = 5,
    parameter int FRA  = 10
`ifdef TMULT_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic aclk,
    input  logic aresetn,
    tmult_arbiter_if.master bus,
    output logic busy
`ifdef TMULT_ARB_TIMEOUT_EN
    ,
    output logic timeout_err
`endif
);
    localparam int W   = EXP + FRA + 1;
    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP{1'b1}}, 1'b1, {(FRA-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  idx_r;
    logic [W-1:0]    a_r, b_r, z_r;
    logic            a_vld_r, b_vld_r, z_rdy_r, rsp_vld_r, busy_r;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  jj;
    logic [W-1:0]    sel_a, sel_b;
    logic [IDW-1:0]  ptr_nxt;
    logic            tmo_exit;

    // Walk the search order backwards so the requester closest to ptr wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        jj        = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            jj = IDW'((int'(ptr) + k) % NREQ);
            if (bus.s_req_tvalid[jj]) begin
                grant     = '0;
                grant[jj] = 1'b1;
                grant_idx = jj;
                sel_a     = bus.s_req_a_tdata[jj*W +: W];
                sel_b     = bus.s_req_b_tdata[jj*W +: W];
            end
        end
    end

    assign ptr_nxt = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    assign bus.s_req_tready = (state == IDLE) ? grant : '0;

`ifdef TMULT_ARB_TIMEOUT_EN
    localparam int TCW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TCW-1:0] wd_cnt;
    logic           tmo_err_r;

    // A product arriving in the same cycle as the limit still wins.
    assign tmo_exit = (state inside {SEND_A, SEND_B, WAIT_Z})
                    && (wd_cnt >= TCW'(TIMEOUT))
                    && !((state == WAIT_Z) && bus.mul_z_tvalid);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wd_cnt    <= '0;
            tmo_err_r <= 1'b0;
        end else begin
            if (state == IDLE)
                wd_cnt <= '0;
            else if (state != RESP)
                wd_cnt <= wd_cnt + 1'b1;
            if (tmo_exit)
                tmo_err_r <= 1'b1;
        end
    end

    assign timeout_err = tmo_err_r;
`else
    assign tmo_exit = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= IDLE;
            ptr       <= '0;
            idx_r     <= '0;
            a_r       <= '0;
            b_r       <= '0;
            z_r       <= '0;
            a_vld_r   <= 1'b0;
            b_vld_r   <= 1'b0;
            z_rdy_r   <= 1'b0;
            rsp_vld_r <= 1'b0;
            busy_r    <= 1'b0;
        end else if (tmo_exit) begin
            // Abandon the operation; the requester still gets an answer (qNaN).
            state     <= RESP;
            z_r       <= QNAN;
            a_vld_r   <= 1'b0;
            b_vld_r   <= 1'b0;
            z_rdy_r   <= 1'b0;
            rsp_vld_r <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        a_r     <= sel_a;
                        b_r     <= sel_b;
                        idx_r   <= grant_idx;
                        ptr     <= ptr_nxt;
                        a_vld_r <= 1'b1;
                        busy_r  <= 1'b1;
                        state   <= SEND_A;
                    end
                end
                SEND_A: begin
                    if (bus.mul_a_tready) begin
                        a_vld_r <= 1'b0;
                        b_vld_r <= 1'b1;
                        state   <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (bus.mul_b_tready) begin
                        b_vld_r <= 1'b0;
                        z_rdy_r <= 1'b1;
                        state   <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (bus.mul_z_tvalid) begin
                        z_r       <= bus.mul_z_tdata;
                        z_rdy_r   <= 1'b0;
                        rsp_vld_r <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.m_rsp_tready) begin
                        rsp_vld_r <= 1'b0;
                        busy_r    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    a_vld_r   <= 1'b0;
                    b_vld_r   <= 1'b0;
                    z_rdy_r   <= 1'b0;
                    rsp_vld_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.mul_a_tdata  = a_r;
    assign bus.mul_a_tvalid = a_vld_r;
    assign bus.mul_b_tdata  = b_r;
    assign bus.mul_b_tvalid = b_vld_r;
    assign bus.mul_z_tready = z_rdy_r;
    assign bus.m_rsp_tdata  = z_r;
    assign bus.m_rsp_tdest  = idx_r;
    assign bus.m_rsp_tvalid = rsp_vld_r;
    assign busy             = busy_r;
endmodule

// File: tb/tb_tmult_arbiter.sv
// tb_tmult_arbiter
//   Directed bench for tmult_arbiter with default parameters (half precision).
//   A small multiplier model returns hand-computed products for known operand
//   pairs; responses and grants are logged each cycle and compared against
//   hand-computed expectations.
module tb_tmult_arbiter;
    localparam int NREQ = 4;
    localparam int EXP  = 5;
    localparam int FRA  = 10;
    localparam int W    = 16;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic busy;
`ifdef TMULT_ARB_TIMEOUT_EN
    logic timeout_err;
`endif

    always #5 aclk = ~aclk;

    tmult_arbiter_if #(.NREQ(NREQ), .EXP(EXP), .FRA(FRA)) bus ();

    tmult_arbiter #(.NREQ(NREQ), .EXP(EXP), .FRA(FRA)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus),
        .busy    (busy)
`ifdef TMULT_ARB_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    int          z_dly      = 0;
    bit          z_never    = 1'b0;
    bit          keep_valid = 1'b0;
    int          grant_q[$];
    logic [15:0] rd_q[$];
    int          rt_q[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] lut(logic [15:0] a, logic [15:0] b);
        case ({a, b})
            32'h4000_4200: return 16'h4600;  //  2.0 *  3.0 =  6.0
            32'h3E00_C000: return 16'hC200;  //  1.5 * -2.0 = -3.0
            32'h3C00_4400: return 16'h4400;  //  1.0 *  4.0 =  4.0
            32'h3800_4000: return 16'h3C00;  //  0.5 *  2.0 =  1.0
            default:       return 16'hFFFF;
        endcase
    endfunction

    function automatic int idx_of(logic [NREQ-1:0] m);
        for (int i = 0; i < NREQ; i++)
            if (m[i]) return i;
        return -1;
    endfunction

    // Multiplier model: A/B always ready, product pulsed for one cycle after z_dly.
    initial begin : mul_model
        logic [15:0] ma, mb;
        int          zcnt;
        bit          pend;
        ma = '0; mb = '0; zcnt = 0; pend = 1'b0;
        bus.mul_a_tready = 1'b1;
        bus.mul_b_tready = 1'b1;
        bus.mul_z_tvalid = 1'b0;
        bus.mul_z_tdata  = '0;
        forever begin
            @(negedge aclk);
            bus.mul_z_tvalid = 1'b0;
            if (!aresetn) begin
                pend = 1'b0;
            end else begin
                if (pend && !z_never) begin
                    if (zcnt == 0) begin
                        bus.mul_z_tvalid = 1'b1;
                        bus.mul_z_tdata  = lut(ma, mb);
                        pend = 1'b0;
                    end else begin
                        zcnt--;
                    end
                end
                if (bus.mul_a_tvalid) ma = bus.mul_a_tdata;
                if (bus.mul_b_tvalid) begin
                    mb   = bus.mul_b_tdata;
                    pend = 1'b1;
                    zcnt = z_dly;
                end
            end
        end
    end

    // One cycle: log grants/responses at negedge, retire accepted requests after the edge.
    task automatic tick();
        logic [NREQ-1:0] acc;
        @(negedge aclk);
        acc = '0;
        if (aresetn) begin
            acc = bus.s_req_tready & bus.s_req_tvalid;
            if (acc != '0) begin
                check("grant_onehot", 32'($onehot(acc)), 32'd1);
                grant_q.push_back(idx_of(acc));
            end
            if (bus.m_rsp_tvalid && bus.m_rsp_tready) begin
                rd_q.push_back(bus.m_rsp_tdata);
                rt_q.push_back(int'(bus.m_rsp_tdest));
            end
        end
        @(posedge aclk);
        #1;
        if (!keep_valid) bus.s_req_tvalid = bus.s_req_tvalid & ~acc;
    endtask

    task automatic issue(int i, logic [15:0] a, logic [15:0] b);
        bus.s_req_a_tdata[i*W +: W] = a;
        bus.s_req_b_tdata[i*W +: W] = b;
        bus.s_req_tvalid[i]         = 1'b1;
    endtask

    task automatic clear_logs();
        grant_q.delete();
        rd_q.delete();
        rt_q.delete();
    endtask

    task automatic wait_rsp(int n, int budget);
        for (int c = 0; c < budget && rd_q.size() < n; c++) tick();
        check("rsp_count", 32'(rd_q.size()), 32'(n));
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (3) tick();
        aresetn = 1'b1;
    endtask

    initial begin
        bus.s_req_a_tdata = '0;
        bus.s_req_b_tdata = '0;
        bus.s_req_tvalid  = '0;
        bus.m_rsp_tready  = 1'b1;
        @(posedge aclk);
        #1;

        // Reset state
        aresetn = 1'b0;
        repeat (3) tick();
        check("rst_outputs",
              {bus.s_req_tready, bus.mul_a_tvalid, bus.mul_b_tvalid, bus.mul_z_tready,
               bus.m_rsp_tvalid, bus.m_rsp_tdata, bus.m_rsp_tdest, busy},
              32'h0);
        aresetn = 1'b1;

        // Single request from requester 2, multi-cycle product
        clear_logs();
        z_dly = 3;
        issue(2, 16'h4000, 16'h4200);
        wait_rsp(1, 100);
        repeat (5) tick();
        check("single_data", rd_q[0], 16'h4600);
        check("single_dest", rt_q[0], 2);
        check("single_grants", 32'(grant_q.size()), 1);
        check("single_gidx", grant_q[0], 2);
        check("single_idle", busy, 0);

        // All four requesters valid right after reset: served 0,1,2,3
        do_reset();
        clear_logs();
        z_dly = 0;
        issue(0, 16'h3C00, 16'h4400);
        issue(1, 16'h3E00, 16'hC000);
        issue(2, 16'h4000, 16'h4200);
        issue(3, 16'h3800, 16'h4000);
        wait_rsp(4, 200);
        for (int k = 0; k < 4; k++) check("all4_dest", rt_q[k], k);
        check("all4_d0", rd_q[0], 16'h4400);
        check("all4_d1", rd_q[1], 16'hC200);
        check("all4_d2", rd_q[2], 16'h4600);
        check("all4_d3", rd_q[3], 16'h3C00);

        // Fairness: requesters 0 and 3 continuously valid
        clear_logs();
        keep_valid = 1'b1;
        z_dly = 1;
        issue(0, 16'h3C00, 16'h4400);
        issue(3, 16'h3800, 16'h4000);
        for (int c = 0; c < 300 && grant_q.size() < 6; c++) tick();
        bus.s_req_tvalid = '0;
        keep_valid = 1'b0;
        wait_rsp(6, 100);
        for (int k = 0; k < 6; k++) begin
            check("fair_grant", grant_q[k], (k % 2 == 0) ? 0 : 3);
            check("fair_dest", rt_q[k], (k % 2 == 0) ? 0 : 3);
            check("fair_data", rd_q[k], (k % 2 == 0) ? 16'h4400 : 16'h3C00);
        end

        // Back-pressure: response held 20 cycles, new request waits
        clear_logs();
        z_dly = 0;
        bus.m_rsp_tready = 1'b0;
        issue(1, 16'h3E00, 16'hC000);
        for (int c = 0; c < 50 && !bus.m_rsp_tvalid; c++) tick();
        check("bp_reached", bus.m_rsp_tvalid, 1);
        issue(0, 16'h3C00, 16'h4400);
        for (int c = 0; c < 20; c++) begin
            tick();
            check("bp_hold",
                  {bus.m_rsp_tvalid, bus.m_rsp_tdata, bus.m_rsp_tdest, bus.mul_a_tvalid,
                   bus.s_req_tready},
                  {1'b1, 16'hC200, 2'd1, 1'b0, 4'b0000});
        end
        bus.m_rsp_tready = 1'b1;
        tick();
        #1;
        check("bp_first_idle_grant", bus.s_req_tready, 4'b0001);
        wait_rsp(2, 100);
        check("bp_d0", rd_q[0], 16'hC200);
        check("bp_t0", rt_q[0], 1);
        check("bp_d1", rd_q[1], 16'h4400);
        check("bp_t1", rt_q[1], 0);

        // Reset in WAIT_Z, then fresh requests see ptr back at 0
        clear_logs();
        z_never = 1'b1;
        issue(2, 16'h4000, 16'h4200);
        for (int c = 0; c < 50 && !bus.mul_z_tready; c++) tick();
        check("mr_in_waitz", {bus.mul_z_tready, busy}, 2'b11);
        aresetn = 1'b0;
        tick();
        check("mr_outputs",
              {bus.s_req_tready, bus.mul_a_tvalid, bus.mul_b_tvalid, bus.mul_z_tready,
               bus.m_rsp_tvalid, bus.m_rsp_tdata, bus.m_rsp_tdest, busy},
              32'h0);
        aresetn = 1'b1;
        z_never = 1'b0;
        clear_logs();
        issue(1, 16'h3E00, 16'hC000);
        issue(3, 16'h3800, 16'h4000);
        wait_rsp(2, 100);
        check("mr_t0", rt_q[0], 1);
        check("mr_d0", rd_q[0], 16'hC200);
        check("mr_t1", rt_q[1], 3);
        check("mr_d1", rd_q[1], 16'h3C00);

`ifdef TMULT_ARB_TIMEOUT_EN
        // Watchdog: multiplier never answers
        clear_logs();
        check("tmo_clear", timeout_err, 0);
        z_never = 1'b1;
        issue(2, 16'h4000, 16'h4200);
        wait_rsp(1, 200);
        check("tmo_data", rd_q[0], 16'h7E00);
        check("tmo_dest", rt_q[0], 2);
        check("tmo_flag", timeout_err, 1);
        z_never = 1'b0;
        clear_logs();
        issue(0, 16'h3C00, 16'h4400);
        wait_rsp(1, 100);
        check("tmo_next_data", rd_q[0], 16'h4400);
        check("tmo_next_dest", rt_q[0], 0);
        check("tmo_sticky", timeout_err, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
